// File: rtl/in_unpack_if.sv
// rtl/in_unpack_if.sv - Control, SRAM read and element-stream signals of in_unpack.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif

interface in_unpack_if #(
    parameter int CNT_WIDTH = 16
) ();
    logic                       start;
    logic [`ADDR_BUS_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]       num_elem;
    logic                       busy;
    logic                       done;
    logic                       sram_cs;
    logic                       sram_oe;
    logic [`ADDR_BUS_WIDTH-1:0] sram_addr;
    logic [`ADDR_BUS_WIDTH-1:0] sram_rdata;
    logic                       out_valid;
    logic                       out_ready;
    logic [`ADDR_BUS_WIDTH-1:0] out_data;
    logic                       out_last;

    modport master (
        output start, base_addr, num_elem, sram_rdata, out_ready,
        input  busy, done, sram_cs, sram_oe, sram_addr, out_valid, out_data, out_last
    );

    modport slave (
        input  start, base_addr, num_elem, sram_rdata, out_ready,
        output busy, done, sram_cs, sram_oe, sram_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/in_unpack.sv
// rtl/in_unpack.sv - Packed int8 SRAM reader that dequantizes and streams one element per cycle.
// Optional IN_UNPACK_RELU_EN clamps negative activations to zero.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif

module in_unpack #(
    parameter int FRAC_BITS = 5,
    parameter int CNT_WIDTH = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rstn,
    in_unpack_if.slave bus
);

    localparam int W  = `ADDR_BUS_WIDTH;
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + 1) + 1;
    localparam logic [PW-1:0] LAST_SLOT = PW'(BUF_DEPTH - 1);
    localparam logic [OW-1:0] DEPTH_O   = OW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t               r_state;
    logic [W-1:0]         r_addr;
    logic [CNT_WIDTH-1:0] r_words_left;
    logic [CNT_WIDTH-1:0] r_elem_left;
    logic                 r_busy;
    logic                 r_done;

    logic [W-1:0]         r_buf [BUF_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [OW-1:0]        r_count;
    logic                 r_rd_pend;
    logic [1:0]           r_lane;

    logic [CNT_WIDTH-1:0] w_nwords;
    logic                 w_issue;
    logic                 w_valid;
    logic                 w_hs;
    logic                 w_last_elem;
    logic                 w_pop;
    logic [W-1:0]         w_head;
    logic [7:0]           w_byte;
    logic [W-1:0]         w_deq;

    assign w_nwords = {2'b00, bus.num_elem[CNT_WIDTH-1:2]}
                    + {{(CNT_WIDTH-1){1'b0}}, |bus.num_elem[1:0]};

    // Credit rule: buffered words plus the read whose data returns this cycle
    assign w_issue = (r_state == FETCH)
                  && ((r_count + {{(OW-1){1'b0}}, r_rd_pend}) < DEPTH_O);

    assign w_valid     = (r_count != '0);
    assign w_hs        = w_valid && bus.out_ready;
    assign w_last_elem = (r_elem_left == CNT_WIDTH'(1));
    assign w_pop       = w_hs && ((r_lane == 2'd3) || w_last_elem);
    assign w_head      = r_buf[r_rd_ptr];

    always_comb begin
        w_byte = w_head[W-1 -: 8];
        unique case (r_lane)
            2'd0: w_byte = w_head[W-1  -: 8];
            2'd1: w_byte = w_head[W-9  -: 8];
            2'd2: w_byte = w_head[W-17 -: 8];
            2'd3: w_byte = w_head[W-25 -: 8];
        endcase
        w_deq = {{(W-8){w_byte[7]}}, w_byte} << FRAC_BITS;
`ifdef IN_UNPACK_RELU_EN
        if (w_byte[7]) begin
            w_deq = '0;
        end
`endif
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sram_cs   = w_issue;
    assign bus.sram_oe   = w_issue;
    assign bus.sram_addr = w_issue ? r_addr : '0;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? w_deq : '0;
    assign bus.out_last  = w_valid && w_last_elem;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_words_left <= '0;
            r_elem_left  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_addr       <= bus.base_addr;
                        r_words_left <= w_nwords;
                        r_elem_left  <= bus.num_elem;
                        r_busy       <= 1'b1;
                        if (bus.num_elem == '0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (w_issue) begin
                        r_addr       <= r_addr + W'(1);
                        r_words_left <= r_words_left - CNT_WIDTH'(1);
                        if (r_words_left == CNT_WIDTH'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_hs && w_last_elem) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_hs) begin
                r_elem_left <= r_elem_left - CNT_WIDTH'(1);
            end
        end
    end

    // Read data is captured the cycle after its address cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_pend <= 1'b0;
            r_lane    <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_rd_pend <= w_issue;
            if (r_rd_pend) begin
                r_buf[r_wr_ptr] <= bus.sram_rdata;
                r_wr_ptr        <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + PW'(1);
                r_lane   <= 2'd0;
            end else if (w_hs) begin
                r_lane <= r_lane + 2'd1;
            end
            unique case ({r_rd_pend, w_pop})
                2'b10:   r_count <= r_count + OW'(1);
                2'b01:   r_count <= r_count - OW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_in_unpack.sv
// tb/tb_in_unpack.sv - Randomized self-checking bench for in_unpack against an element-level model.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif

module tb_in_unpack;

    localparam int FRAC  = 5;
    localparam int DEPTH = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    int n_checks = 0;
    int n_errors = 0;

    in_unpack_if #(.CNT_WIDTH(16)) bus ();

    in_unpack #(
        .FRAC_BITS(FRAC),
        .CNT_WIDTH(16),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [256];

    always @(posedge clk) begin
        bus.sram_rdata <= (bus.sram_cs && bus.sram_oe) ? mem[bus.sram_addr[7:0]] : $urandom;
    end

    logic [31:0] rd_a [$];
    int          rd_c [$];
    logic [31:0] hs_d [$];
    logic        hs_l [$];
    int          hs_c [$];
    int          done_c [$];
    int          vrise_c [$];
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic        prev_v = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall <= 1'b0;
            prev_v     <= 1'b0;
        end else begin
            if (bus.sram_cs && bus.sram_oe) begin
                rd_a.push_back(bus.sram_addr);
                rd_c.push_back(cyc);
            end
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_d || bus.out_last !== prev_l))
                stab_err <= stab_err + 1;
            if (bus.out_valid && !prev_v) vrise_c.push_back(cyc);
            if (bus.out_valid && bus.out_ready) begin
                hs_d.push_back(bus.out_data);
                hs_l.push_back(bus.out_last);
                hs_c.push_back(cyc);
            end
            if (bus.done) done_c.push_back(cyc);
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_v     <= bus.out_valid;
            prev_d     <= bus.out_data;
            prev_l     <= bus.out_last;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_elem(input logic [31:0] base, input int i);
        logic [31:0] w;
        int b;
        int v;
        w = mem[(int'(base) + i / 4) % 256];
        b = int'((w >> (8 * (3 - i % 4))) & 32'hFF);
        v = (b > 127) ? b - 256 : b;
`ifdef IN_UNPACK_RELU_EN
        if (v < 0) v = 0;
`endif
        return 32'(v * (1 << FRAC));
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"},      bus.busy, 0);
        check({tag, ".done"},      bus.done, 0);
        check({tag, ".sram_cs"},   bus.sram_cs, 0);
        check({tag, ".sram_oe"},   bus.sram_oe, 0);
        check({tag, ".sram_addr"}, bus.sram_addr, 0);
        check({tag, ".out_valid"}, bus.out_valid, 0);
        check({tag, ".out_data"},  bus.out_data, 0);
        check({tag, ".out_last"},  bus.out_last, 0);
    endtask

    task automatic run_xfer(input logic [31:0] base, input int n, input int rmode,
                            input int abort_after, input bit dbl);
        int rd0, h0, d0, v0, s0, start_cyc, nw, nrd, ng, pops, bad, lim;
        bit aborted;
        aborted = 1'b0;
        rd0 = rd_a.size(); h0 = hs_d.size(); d0 = done_c.size(); v0 = vrise_c.size(); s0 = stab_err;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.base_addr = base;
        bus.num_elem  = 16'(n);
        bus.start     = 1'b1;
        start_cyc     = cyc;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.base_addr = $urandom;
        bus.num_elem  = 16'($urandom);
        check("busy_after_start", bus.busy, 1);
        for (int c = 0; c < 2000; c++) begin
            if (done_c.size() > d0) break;
            if (abort_after > 0 && hs_d.size() - h0 >= abort_after) begin
                aborted = 1'b1;
                break;
            end
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (c % 3 == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (dbl && c == 2) begin
                bus.start     = 1'b1;
                bus.base_addr = base + 100;
                bus.num_elem  = 16'(n + 3);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;

        if (aborted) begin
            ng = hs_d.size() - h0;
            for (int k = 0; k < ng && k < n; k++)
                check($sformatf("pre_rst_data[%0d]", k), hs_d[h0 + k], exp_elem(base, k));
            rstn = 1'b0;
            @(negedge clk);
            check_reset_outputs("rst_mid_a");
            @(negedge clk);
            check_reset_outputs("rst_mid_b");
            @(posedge clk); #1;
            rstn = 1'b1;
            return;
        end

        if (done_c.size() == d0) check("timeout", 0, 1);
        repeat (6) @(posedge clk);
        #1;

        nw  = (n + 3) / 4;
        nrd = rd_a.size() - rd0;
        check("n_reads", nrd, nw);
        lim = (nrd < nw) ? nrd : nw;
        for (int j = 0; j < lim; j++)
            check($sformatf("raddr[%0d]", j), rd_a[rd0 + j], base + 32'(j));

        ng = hs_d.size() - h0;
        check("n_elem", ng, n);
        for (int k = 0; k < ng && k < n; k++) begin
            check($sformatf("data[%0d]", k), hs_d[h0 + k], exp_elem(base, k));
            check($sformatf("last[%0d]", k), hs_l[h0 + k], (k == n - 1));
        end

        check("n_done", done_c.size() - d0, 1);
        if (done_c.size() > d0) begin
            if (n == 0) check("done_lat", done_c[d0] - start_cyc, 1);
            else if (ng >= n) check("done_lat", done_c[d0] - hs_c[h0 + n - 1], 1);
        end

        check("stable", stab_err - s0, 0);

        bad = 0;
        for (int j = 0; j < nrd; j++) begin
            pops = 0;
            for (int k = 0; k < ng; k++)
                if ((k % 4 == 3 || k == n - 1) && hs_c[h0 + k] < rd_c[rd0 + j]) pops++;
            if (j + 1 - pops > DEPTH) bad++;
        end
        check("credit", bad, 0);

        if (n == 0) check("no_valid", vrise_c.size() - v0, 0);
        else if (vrise_c.size() > v0) check("first_valid_lat", (vrise_c[v0] - start_cyc) >= 2, 1);

        if (rmode == 0 && n > 0 && ng == n)
            check("no_bubble", hs_c[h0 + n - 1] - hs_c[h0], n - 1);

        check("idle_busy", bus.busy, 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_elem  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h10] = 32'h7F80_01FF;

        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk); #1;
        rstn = 1'b1;

        run_xfer(32'h10, 4, 0, 0, 1'b0);
        run_xfer(32'h20, 6, 0, 0, 1'b0);
        run_xfer(32'h30, 0, 0, 0, 1'b0);
        run_xfer(32'h40, 16, 1, 0, 1'b0);
        run_xfer(32'h60, 16, 0, 5, 1'b0);
        run_xfer(32'h90, 4, 0, 0, 1'b0);
        run_xfer(32'hA0, 8, 0, 0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            run_xfer(32'($urandom_range(0, 180)), int'($urandom_range(1, 22)),
                     int'($urandom_range(0, 2)), 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/in_unpack.md
Name: in_unpack

Overview:
- Read-side counterpart of the quantized output packer.
- Fetches packed 32-bit SRAM words, each holding four int8 activations, with element 0 in bits [31:24] and element 3 in bits [7:0].
- Dequantizes each activation back into the 32-bit accumulator fixed-point domain.
- Streams elements one per cycle to the PE array over a valid/ready handshake, with a small prefetch buffer.

Parameters:
- FRAC_BITS, 5: left shift applied after sign extension; matches the packer's [12:5] extraction.
- CNT_WIDTH, 16: width of the element count and the internal counters.
- BUF_DEPTH, 2: packed-word prefetch buffer entries; must be at least 2.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that launches a transfer; ignored while busy=1
- base_addr  input  `ADDR_BUS_WIDTH  word address of the first packed word; sampled on start
- num_elem  input  CNT_WIDTH  number of int8 elements to deliver; sampled on start
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse after the last element handshake
- sram_cs  output  1  SRAM chip select
- sram_oe  output  1  SRAM read enable
- sram_addr  output  `ADDR_BUS_WIDTH  SRAM word address
- sram_rdata  input  `ADDR_BUS_WIDTH  SRAM read data, valid 1 cycle after the address cycle
- out_valid  output  1  out_data holds an element
- out_ready  input  1  consumer accepts the element
- out_data  output  `ADDR_BUS_WIDTH  dequantized element
- out_last  output  1  current element is the final one of the transfer

Behaviour:
- Reset (rstn=0, asynchronous):
  - All outputs go to 0; FSM goes to IDLE.
  - Buffer is emptied; counters are cleared.
  - Any in-flight SRAM read is discarded.
- FSM states: IDLE, FETCH, DRAIN, FIN.
  - IDLE -> FETCH on start with num_elem!=0.
  - IDLE -> FIN on start with num_elem==0: no SRAM access; done pulses 1 cycle after start.
  - FETCH -> DRAIN when the last word read has been issued.
  - DRAIN -> FIN on the handshake of the last element.
  - FIN -> IDLE unconditionally. done=1 for exactly that cycle.
- Word count: nwords = ceil(num_elem/4).
- Word addresses are base_addr, base_addr+1, ... base_addr+nwords-1, with no wrap protection.
- Read issue: in FETCH, assert sram_cs=sram_oe=1 with sram_addr only if (buffer occupancy + in-flight reads) < BUF_DEPTH. At most 1 read is issued per cycle.
- Read capture: the word is written into the buffer on the cycle after its issue. Because of the credit rule the buffer never overflows.
- Unpack:
  - The head word is presented lane by lane: lane 0 = [31:24], then [23:16], [15:8], [7:0].
  - out_data = sign_extend_32(byte) << FRAC_BITS. Example: byte 0x80 gives 0xFFFF_F000.
- Popping the head word:
  - The head word pops on the handshake of lane 3, or of the final element if that comes earlier.
  - In a partial last word, lanes past num_elem are never presented.
- Handshake:
  - A handshake occurs when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_data and out_last hold stable.
  - out_valid stays asserted until the handshake.
  - The first out_valid appears no earlier than 2 cycles after start (address cycle plus data cycle).
- Throughput:
  - With out_ready tied high and SRAM returning every cycle, one element per cycle.
  - Each word is reused for 4 cycles, so fetching stalls on the credit rule and no bubbles appear.
- Simultaneous events:
  - A buffer write and a buffer pop in the same cycle both take effect; occupancy is unchanged.
  - A read issue may occur in the same cycle a pop frees a slot.
- out_last is high only for the element whose index is num_elem-1.
- start while busy is ignored; base_addr and num_elem are not re-sampled.

Optional Feature:
- Macro: IN_UNPACK_RELU_EN.
- Defined: a negative byte produces out_data=0 while keeping its slot, valid and last timing. Example: 0x80 gives 0x0000_0000, 0x7F gives 0x0000_0FE0.
- Undefined: the plain sign-extended dequantization above.

Test Plan:
- num_elem=4, base_addr=0x10, mem[0x10]=0x7F80_01FF, out_ready=1 -> exactly one read at 0x10. Outputs in order: 0x0000_0FE0, 0xFFFF_F000, 0x0000_0020, 0xFFFF_FFE0. out_last on the 4th; done pulses 1 cycle after the 4th handshake.
- num_elem=6 -> reads at base and base+1 only. The 2nd word yields 2 elements; out_last is on element 5; lanes 2-3 of word 2 are never output.
- num_elem=0 -> no sram_cs, no out_valid; done pulses 1 cycle after start.
- num_elem=16, out_ready toggling 1,0,0,1,... -> out_data stable during stalls; the element sequence equals the reference unpacking.
  - Buffer occupancy plus in-flight reads never exceeds BUF_DEPTH.
  - Exactly 4 reads are issued.
- rstn pulled low mid-transfer (after element 5 of 16), then start reissued with num_elem=4 -> all outputs 0 during reset; the new transfer starts at the new base_addr with no stale data.
- Second start pulse while busy -> ignored; element count and addresses match the first transfer only.
